// File: rtl/multi_phase_traffic_controller.sv
// multi_phase_traffic_controller
//
// Round-robin traffic light controller for N_PHASES approaches with
// pedestrian walk extension and emergency preemption.
//
// Sequence per phase: ALLRED -> GREEN -> YELLOW -> ALLRED (next phase).
// An emergency request either truncates the running green (other phase)
// or converts it directly into an emergency hold (same phase). The
// emergency phase becomes the target at the ALLRED exit.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   pred_req     per-phase pedestrian request (level or pulse, sticky)
//   emergency    per-phase emergency preemption request (level)
//   light        phase k at [2k+1:2k]: 00 red, 01 yellow, 10 green
//   pred_signal  per-phase walk indication
//   emerg_active high while an emergency green is held
//   cur_phase    phase owning (or about to own) the green
//
// All outputs are registered. They are computed from the next-state
// values, so a change decided on an edge is visible right after it.
module multi_phase_traffic_controller #(
    parameter int N_PHASES   = 4,
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int PED_CYC    = 10,
    localparam int PW        = (N_PHASES > 2) ? $clog2(N_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_PHASES-1:0]   pred_req,
    input  logic [N_PHASES-1:0]   emergency,
    output logic [2*N_PHASES-1:0] light,
    output logic [N_PHASES-1:0]   pred_signal,
    output logic                  emerg_active,
    output logic [PW-1:0]         cur_phase
);
    // A served pedestrian request stretches the green to cover the walk.
    localparam int PED_GREEN = (PED_CYC > GREEN_CYC) ? PED_CYC : GREEN_CYC;
    localparam int MAX_A     = (PED_GREEN > YELLOW_CYC) ? PED_GREEN : YELLOW_CYC;
    localparam int MAX_D     = (MAX_A > ALLRED_CYC) ? MAX_A : ALLRED_CYC;
    localparam int CW        = $clog2(MAX_D + 1);

    localparam logic [CW-1:0] CNT_GREEN  = CW'(GREEN_CYC - 1);
    localparam logic [CW-1:0] CNT_PEDGRN = CW'(PED_GREEN - 1);
    localparam logic [CW-1:0] CNT_YELLOW = CW'(YELLOW_CYC - 1);
    localparam logic [CW-1:0] CNT_ALLRED = CW'(ALLRED_CYC - 1);
    // Walk is shown while the counter is at or above this value, i.e. the
    // first PED_CYC cycles of a pedestrian-stretched green.
    localparam logic [CW-1:0] CNT_PED_LO = CW'(PED_GREEN - PED_CYC);
    localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

    typedef enum logic [1:0] {
        ST_ALLRED,
        ST_GREEN,
        ST_YELLOW,
        ST_EMERG
    } state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [PW-1:0]           phase_reg, phase_next;
    logic [N_PHASES-1:0]     ped_pending_reg, ped_pending_next;
    logic                    served_reg, served_next;
    logic [2*N_PHASES-1:0]   light_reg, light_next;
    logic [N_PHASES-1:0]     ped_sig_reg, ped_sig_next;
    logic                    emerg_active_reg, emerg_active_next;

    logic                    emerg_any;
    logic [PW-1:0]           emerg_sel;

    // Lowest-index emergency request wins.
    always_comb begin
        emerg_sel = '0;
        for (int i = N_PHASES - 1; i >= 0; i--) begin
            if (emergency[i]) emerg_sel = PW'(i);
        end
    end
    assign emerg_any = |emergency;

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        phase_next       = phase_reg;
        served_next      = served_reg;
        ped_pending_next = ped_pending_reg | pred_req;

        case (state_reg)
            ST_ALLRED: begin
                if (cnt_reg == '0) begin
                    if (emerg_any) begin
                        phase_next = emerg_sel;
                        state_next = ST_EMERG;
                    end else begin
                        state_next = ST_GREEN;
                        // A request on the entry edge itself is served now.
                        served_next = 1'b0;
                        for (int k = 0; k < N_PHASES; k++) begin
                            if (PW'(k) == phase_reg) begin
                                served_next         = ped_pending_next[k];
                                ped_pending_next[k] = 1'b0;
                            end
                        end
                        cnt_next = served_next ? CNT_PEDGRN : CNT_GREEN;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_GREEN: begin
                if (emerg_any) begin
                    if (emerg_sel == phase_reg) begin
                        // Same phase: keep the green, skip yellow, freeze counter.
                        state_next = ST_EMERG;
                    end else begin
                        state_next = ST_YELLOW;
                        cnt_next   = CNT_YELLOW;
                    end
                end else if (cnt_reg == '0) begin
                    state_next = ST_YELLOW;
                    cnt_next   = CNT_YELLOW;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_YELLOW: begin
                if (cnt_reg == '0) begin
                    state_next = ST_ALLRED;
                    cnt_next   = CNT_ALLRED;
                    phase_next = (phase_reg == LAST_PHASE) ? '0 : phase_reg + 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_EMERG: begin
                if (!emergency[phase_reg]) begin
                    state_next = ST_YELLOW;
                    cnt_next   = CNT_YELLOW;
                end
            end
            default: begin
                state_next = ST_ALLRED;
                cnt_next   = CNT_ALLRED;
            end
        endcase

        // Output decode from the next-state values.
        light_next        = '0;
        ped_sig_next      = '0;
        emerg_active_next = (state_next == ST_EMERG);
        for (int k = 0; k < N_PHASES; k++) begin
            if (PW'(k) == phase_next) begin
                if (state_next == ST_GREEN || state_next == ST_EMERG) begin
                    light_next[2*k +: 2] = 2'b10;
                end else if (state_next == ST_YELLOW) begin
                    light_next[2*k +: 2] = 2'b01;
                end
                ped_sig_next[k] = (state_next == ST_GREEN) && served_next &&
                                  (cnt_next >= CNT_PED_LO);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_ALLRED;
            cnt_reg          <= CNT_ALLRED;
            phase_reg        <= '0;
            ped_pending_reg  <= '0;
            served_reg       <= 1'b0;
            light_reg        <= '0;
            ped_sig_reg      <= '0;
            emerg_active_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            phase_reg        <= phase_next;
            ped_pending_reg  <= ped_pending_next;
            served_reg       <= served_next;
            light_reg        <= light_next;
            ped_sig_reg      <= ped_sig_next;
            emerg_active_reg <= emerg_active_next;
        end
    end

    assign light        = light_reg;
    assign pred_signal  = ped_sig_reg;
    assign emerg_active = emerg_active_reg;
    assign cur_phase    = phase_reg;

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Testbench for multi_phase_traffic_controller.
// Main instance uses default parameters; a second instance uses
// PED_CYC=30 for the long-walk case. Vector table: each record optionally
// restarts from reset, applies inputs, advances wait_n clocks and compares.
module tb_multi_phase_traffic_controller;
    logic       clk;
    logic       reset;
    logic [3:0] pred_req, emergency;
    logic [7:0] light;
    logic [3:0] pred_signal;
    logic       emerg_active;
    logic [1:0] cur_phase;

    logic [3:0] pred_req2, emergency2;
    logic [7:0] light2;
    logic [3:0] pred_signal2;
    logic       emerg_active2;
    logic [1:0] cur_phase2;

    int total = 0;
    int bad   = 0;

    multi_phase_traffic_controller dut (
        .clk(clk), .reset(reset), .pred_req(pred_req), .emergency(emergency),
        .light(light), .pred_signal(pred_signal), .emerg_active(emerg_active),
        .cur_phase(cur_phase)
    );

    multi_phase_traffic_controller #(.PED_CYC(30)) dut_ped30 (
        .clk(clk), .reset(reset), .pred_req(pred_req2), .emergency(emergency2),
        .light(light2), .pred_signal(pred_signal2), .emerg_active(emerg_active2),
        .cur_phase(cur_phase2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        int         wait_n;
        logic [3:0] preq;
        logic [3:0] em;
        logic [7:0] light;
        logic [3:0] ped;
        logic       ea;
        logic [1:0] ph;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input int w, input logic [3:0] p, input logic [3:0] e,
                       input logic [7:0] l, input logic [3:0] ps, input logic a,
                       input logic [1:0] ph);
        vec_t v;
        v.rst = r; v.wait_n = w; v.preq = p; v.em = e;
        v.light = l; v.ped = ps; v.ea = a; v.ph = ph;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pred_req = '0;
        emergency = '0;
        pred_req2 = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        pred_req = '0;
        emergency = '0;
        pred_req2 = '0;
        emergency2 = '0;

        // Release -> 2 red, phase 0 green 20, yellow 4, red 2, phase 1 green
        // with the pedestrian request pulsed during phase-0 green.
        add(1, 0, 4'h0, 4'h0, 8'h00, 4'h0, 0, 2'd0);
        add(0, 1, 4'h0, 4'h0, 8'h00, 4'h0, 0, 2'd0);
        add(0, 1, 4'h0, 4'h0, 8'h02, 4'h0, 0, 2'd0);
        add(0, 1, 4'h2, 4'h0, 8'h02, 4'h0, 0, 2'd0);
        add(0, 18, 4'h0, 4'h0, 8'h02, 4'h0, 0, 2'd0);
        add(0, 1, 4'h0, 4'h0, 8'h01, 4'h0, 0, 2'd0);
        add(0, 3, 4'h0, 4'h0, 8'h01, 4'h0, 0, 2'd0);
        add(0, 1, 4'h0, 4'h0, 8'h00, 4'h0, 0, 2'd1);
        add(0, 1, 4'h0, 4'h0, 8'h00, 4'h0, 0, 2'd1);
        add(0, 1, 4'h0, 4'h0, 8'h08, 4'h2, 0, 2'd1);
        add(0, 9, 4'h0, 4'h0, 8'h08, 4'h2, 0, 2'd1);
        add(0, 1, 4'h0, 4'h0, 8'h08, 4'h0, 0, 2'd1);
        add(0, 9, 4'h0, 4'h0, 8'h08, 4'h0, 0, 2'd1);
        add(0, 1, 4'h0, 4'h0, 8'h04, 4'h0, 0, 2'd1);
        // Emergency[2] at green cycle 5 held 30 cycles.
        add(1, 6, 4'h0, 4'h0, 8'h02, 4'h0, 0, 2'd0);
        add(0, 1, 4'h0, 4'h4, 8'h01, 4'h0, 0, 2'd0);
        add(0, 3, 4'h0, 4'h4, 8'h01, 4'h0, 0, 2'd0);
        add(0, 1, 4'h0, 4'h4, 8'h00, 4'h0, 0, 2'd1);
        add(0, 2, 4'h0, 4'h4, 8'h20, 4'h0, 1, 2'd2);
        add(0, 23, 4'h0, 4'h4, 8'h20, 4'h0, 1, 2'd2);
        add(0, 1, 4'h0, 4'h0, 8'h10, 4'h0, 0, 2'd2);
        add(0, 4, 4'h0, 4'h0, 8'h00, 4'h0, 0, 2'd3);
        add(0, 2, 4'h0, 4'h0, 8'h80, 4'h0, 0, 2'd3);
        // Emergency[1] and [3] together; [3] still held after [1] drops.
        add(1, 4, 4'h0, 4'h0, 8'h02, 4'h0, 0, 2'd0);
        add(0, 1, 4'h0, 4'hA, 8'h01, 4'h0, 0, 2'd0);
        add(0, 4, 4'h0, 4'hA, 8'h00, 4'h0, 0, 2'd1);
        add(0, 2, 4'h0, 4'hA, 8'h08, 4'h0, 1, 2'd1);
        add(0, 5, 4'h0, 4'hA, 8'h08, 4'h0, 1, 2'd1);
        add(0, 1, 4'h0, 4'h8, 8'h04, 4'h0, 0, 2'd1);
        add(0, 4, 4'h0, 4'h8, 8'h00, 4'h0, 0, 2'd2);
        add(0, 2, 4'h0, 4'h8, 8'h80, 4'h0, 1, 2'd3);
        add(0, 1, 4'h0, 4'h0, 8'h40, 4'h0, 0, 2'd3);
        add(0, 4, 4'h0, 4'h0, 8'h00, 4'h0, 0, 2'd0);
        add(0, 2, 4'h0, 4'h0, 8'h02, 4'h0, 0, 2'd0);
        // Same pair, both released together -> normal rotation to phase 2.
        add(1, 4, 4'h0, 4'h0, 8'h02, 4'h0, 0, 2'd0);
        add(0, 1, 4'h0, 4'hA, 8'h01, 4'h0, 0, 2'd0);
        add(0, 6, 4'h0, 4'hA, 8'h08, 4'h0, 1, 2'd1);
        add(0, 5, 4'h0, 4'hA, 8'h08, 4'h0, 1, 2'd1);
        add(0, 1, 4'h0, 4'h0, 8'h04, 4'h0, 0, 2'd1);
        add(0, 4, 4'h0, 4'h0, 8'h00, 4'h0, 0, 2'd2);
        add(0, 2, 4'h0, 4'h0, 8'h20, 4'h0, 0, 2'd2);
        // Emergency on the green phase itself, with pending ped for phase 1.
        add(1, 4, 4'h0, 4'h0, 8'h02, 4'h0, 0, 2'd0);
        add(0, 1, 4'h2, 4'h1, 8'h02, 4'h0, 1, 2'd0);
        add(0, 5, 4'h0, 4'h1, 8'h02, 4'h0, 1, 2'd0);
        add(0, 1, 4'h0, 4'h0, 8'h01, 4'h0, 0, 2'd0);
        add(0, 4, 4'h0, 4'h0, 8'h00, 4'h0, 0, 2'd1);
        add(0, 2, 4'h0, 4'h0, 8'h08, 4'h2, 0, 2'd1);

        // Reset state while reset is held.
        #12;
        chk("rst_light", -1, 32'(light), 32'h0);
        chk("rst_ped", -1, 32'(pred_signal), 32'h0);
        chk("rst_emerg", -1, 32'(emerg_active), 32'h0);
        chk("rst_phase", -1, 32'(cur_phase), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            pred_req  = vecs[i].preq;
            emergency = vecs[i].em;
            step(vecs[i].wait_n);
            chk("light", i, 32'(light), 32'(vecs[i].light));
            chk("pred_signal", i, 32'(pred_signal), 32'(vecs[i].ped));
            chk("emerg_active", i, 32'(emerg_active), 32'(vecs[i].ea));
            chk("cur_phase", i, 32'(cur_phase), 32'(vecs[i].ph));
            $display("vec %0d: light=%h ped=%h ea=%0d phase=%0d", i, light, pred_signal,
                     emerg_active, cur_phase);
        end

        // Asynchronous reset in the middle of yellow, then restart.
        do_reset();
        step(23);
        chk("mid_yellow", 100, 32'(light), 32'h01);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_light", 101, 32'(light), 32'h0);
        chk("async_rst_phase", 101, 32'(cur_phase), 32'h0);
        chk("async_rst_emerg", 101, 32'(emerg_active), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1);
        chk("restart_red", 102, 32'(light), 32'h00);
        step(1);
        chk("restart_green", 103, 32'(light), 32'h02);
        $display("seq async reset: light=%h phase=%0d", light, cur_phase);

        // Long walk: PED_CYC=30 stretches phase-0 green to 30 cycles, walk on throughout.
        reset = 1'b0;
        pred_req = '0;
        emergency = '0;
        pred_req2 = 4'b0001;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1);
        pred_req2 = '0;
        step(1);
        chk("ped30_first_light", 200, 32'(light2), 32'h02);
        chk("ped30_first_walk", 200, 32'(pred_signal2), 32'h1);
        step(29);
        chk("ped30_last_light", 201, 32'(light2), 32'h02);
        chk("ped30_last_walk", 201, 32'(pred_signal2), 32'h1);
        step(1);
        chk("ped30_yellow", 202, 32'(light2), 32'h01);
        chk("ped30_walk_off", 202, 32'(pred_signal2), 32'h0);
        $display("seq ped30: light=%h ped=%h", light2, pred_signal2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
